// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid-buffered pipeline register.
//
// Sits between two datapath stages and passes words downstream with a
// valid/ready handshake on each side. It sustains one word per cycle, and it
// can absorb a full downstream stall without a combinational ready path going
// back upstream. A synchronous flush drops all held words.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset; takes priority over i_flush
//   i_flush      synchronous squash; the block is empty from the next edge
//   i_in         upstream data word
//   i_in_valid   upstream word present
//   o_in_ready   block can accept a word this cycle
//   o_out        downstream data word (always the main register)
//   o_out_valid  main register holds a valid word
//   i_out_ready  downstream consumes the head word this cycle
//   o_count      number of held words (0..2)
//
// State   | meaning
// --------+-------------------------------------------
// EMPTY   | no words held, o_count = 0
// ONE     | main valid, skid free, o_count = 1
// FULL    | main and skid valid, upstream stalled, o_count = 2

module pipe_skid #(
    parameter int SIZE = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic [SIZE-1:0] i_in,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    output logic [SIZE-1:0] o_out,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [1:0]      o_count
);

    // The encoding doubles as the held-word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SIZE-1:0] r_main;
    logic [SIZE-1:0] r_skid;

    logic w_accept;
    logic w_pop;
    logic w_main_load;
    logic w_main_from_skid;
    logic w_skid_load;

    // Handshake outputs come from the state register only, so no input
    // reaches an output combinationally.
    assign o_in_ready  = (r_state != FULL);
    assign o_out_valid = (r_state != EMPTY);
    assign o_count     = r_state;
    assign o_out       = r_main;

    assign w_accept = i_in_valid & o_in_ready;
    assign w_pop    = o_out_valid & i_out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;

        unique case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_main_load = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && !w_pop) begin
                    w_state_nxt = FULL;
                    w_skid_load = 1'b1;
                end else if (w_pop && !w_accept) begin
                    w_state_nxt = EMPTY;
                end else if (w_pop && w_accept) begin
                    w_main_load = 1'b1;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_nxt      = ONE;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = EMPTY;
            end
        endcase

        // Flush empties the block but leaves the data registers untouched.
        if (i_flush) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_load) begin
                r_main <= w_main_from_skid ? r_skid : i_in;
            end
            if (w_skid_load) begin
                r_skid <= i_in;
            end
        end
    end

endmodule
